// File: rtl/pcpi_serial_bridge_if.sv
// rtl/pcpi_serial_bridge_if.sv - host segment channels and PCPI bus bundle for pcpi_serial_bridge
interface pcpi_serial_bridge_if #(
  parameter int SEG_W  = 4,
  parameter int WORD_W = 32
);
  // host load channel
  logic [SEG_W-1:0]  seg_in;
  logic              seg_req;
  logic              seg_ack;
  // host read channel and status
  logic              rd_req;
  logic              rd_ack;
  logic [SEG_W-1:0]  res_seg;
  logic              res_avail;
  logic              busy;
  logic              err;
  // coprocessor side
  logic              pcpi_valid;
  logic [WORD_W-1:0] pcpi_insn;
  logic              pcpi_ready;
  logic              pcpi_wr;
  logic              pcpi_wait;
  logic [WORD_W-1:0] pcpi_rd;

  modport master (
    output seg_in, seg_req, rd_req, pcpi_ready, pcpi_wr, pcpi_wait, pcpi_rd,
    input  seg_ack, rd_ack, res_seg, res_avail, busy, err, pcpi_valid, pcpi_insn
  );

  modport slave (
    input  seg_in, seg_req, rd_req, pcpi_ready, pcpi_wr, pcpi_wait, pcpi_rd,
    output seg_ack, rd_ack, res_seg, res_avail, busy, err, pcpi_valid, pcpi_insn
  );
endinterface

// File: rtl/pcpi_serial_bridge.sv
// rtl/pcpi_serial_bridge.sv - segment-serial host to PCPI bridge; optional watchdog under PCPI_TIMEOUT_EN
module pcpi_serial_bridge #(
  parameter int SEG_W   = 4,
  parameter int WORD_W  = 32,
  parameter int TIMEOUT = 255
) (
  input logic               clk,
  input logic               rst_n,
  pcpi_serial_bridge_if.slave bus
);
  localparam int NSEG = WORD_W / SEG_W;
  localparam int CW   = (NSEG > 1) ? $clog2(NSEG) : 1;
  localparam logic [CW-1:0] LAST_SEG = CW'(NSEG - 1);

  typedef enum logic [1:0] {LOAD, EXEC, DRAIN} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [CW-1:0]     rd_cnt_q, rd_cnt_d;
  logic              seg_ack_q, seg_ack_d;
  logic              rd_ack_q, rd_ack_d;
  logic              valid_q, valid_d;
  logic [WORD_W-1:0] insn_q, insn_d;
  logic [WORD_W-1:0] res_q, res_d;

`ifdef PCPI_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [WW-1:0] TIMEOUT_W = WW'(TIMEOUT);
  logic              err_q, err_d;
  logic [WW-1:0]     wdog_q, wdog_d;
`else
  // watchdog inputs have no consumer in this build
  logic              unused_wdog;
  assign unused_wdog = bus.pcpi_wait ^ (TIMEOUT > 0);
`endif

  // state and datapath registers; reset drops any partial word, request or result
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= LOAD;
      cnt_q     <= '0;
      rd_cnt_q  <= '0;
      seg_ack_q <= 1'b0;
      rd_ack_q  <= 1'b0;
      valid_q   <= 1'b0;
      insn_q    <= '0;
      res_q     <= '0;
`ifdef PCPI_TIMEOUT_EN
      err_q     <= 1'b0;
      wdog_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rd_cnt_q  <= rd_cnt_d;
      seg_ack_q <= seg_ack_d;
      rd_ack_q  <= rd_ack_d;
      valid_q   <= valid_d;
      insn_q    <= insn_d;
      res_q     <= res_d;
`ifdef PCPI_TIMEOUT_EN
      err_q     <= err_d;
      wdog_q    <= wdog_d;
`endif
    end
  end

  // next-state: handshakes, PCPI issue and result drain
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rd_cnt_d  = rd_cnt_q;
    seg_ack_d = seg_ack_q;
    rd_ack_d  = rd_ack_q;
    valid_d   = valid_q;
    insn_d    = insn_q;
    res_d     = res_q;
`ifdef PCPI_TIMEOUT_EN
    err_d     = err_q;
    wdog_d    = '0;
`endif
    // acks release on a low request in every state so none is left hanging
    if (!bus.seg_req) seg_ack_d = 1'b0;
    if (!bus.rd_req)  rd_ack_d  = 1'b0;

    case (state_q)
      LOAD: begin
        if (bus.seg_req && !seg_ack_q) begin
          insn_d[cnt_q*SEG_W +: SEG_W] = bus.seg_in;
          seg_ack_d = 1'b1;
`ifdef PCPI_TIMEOUT_EN
          err_d = 1'b0;
`endif
          if (cnt_q == LAST_SEG) begin
            cnt_d   = '0;
            state_d = EXEC;
            valid_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      EXEC: begin
        if (bus.pcpi_ready) begin
          valid_d = 1'b0;
          if (bus.pcpi_wr) begin
            res_d    = bus.pcpi_rd;
            rd_cnt_d = '0;
            state_d  = DRAIN;
          end else begin
            state_d = LOAD;
          end
        end
`ifdef PCPI_TIMEOUT_EN
        else if (bus.pcpi_wait) begin
          wdog_d = '0;
        end else if (wdog_q + 1'b1 == TIMEOUT_W) begin
          valid_d = 1'b0;
          err_d   = 1'b1;
          state_d = LOAD;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
`endif
      end
      DRAIN: begin
        if (bus.rd_req && !rd_ack_q) begin
          rd_ack_d = 1'b1;
        end else if (!bus.rd_req && rd_ack_q) begin
          if (rd_cnt_q == LAST_SEG) begin
            rd_cnt_d = '0;
            state_d  = LOAD;
          end else begin
            rd_cnt_d = rd_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = LOAD;
    endcase
  end

  assign bus.seg_ack    = seg_ack_q;
  assign bus.rd_ack     = rd_ack_q;
  assign bus.pcpi_valid = valid_q;
  assign bus.pcpi_insn  = insn_q;
  assign bus.busy       = (state_q != LOAD);
  assign bus.res_avail  = (state_q == DRAIN);
  assign bus.res_seg    = (state_q == DRAIN) ? res_q[rd_cnt_q*SEG_W +: SEG_W] : '0;
`ifdef PCPI_TIMEOUT_EN
  assign bus.err        = err_q;
`else
  assign bus.err        = 1'b0;
`endif
endmodule

// File: tb/tb_pcpi_serial_bridge.sv
// tb/tb_pcpi_serial_bridge.sv - directed self-checking bench for pcpi_serial_bridge
module tb_pcpi_serial_bridge;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int vectors = 0;
  int miscompares = 0;

  pcpi_serial_bridge_if #(.SEG_W(4), .WORD_W(32)) bus ();

  pcpi_serial_bridge #(.SEG_W(4), .WORD_W(32), .TIMEOUT(255)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_seg(input logic [3:0] v);
    bus.seg_in  = v;
    bus.seg_req = 1'b1;
    step();
    vectors++;
    if (bus.seg_ack !== 1'b1) begin
      miscompares++;
      $display("FAIL seg_ack_rise got %b want 1", bus.seg_ack);
    end
    bus.seg_req = 1'b0;
    step();
    vectors++;
    if (bus.seg_ack !== 1'b0) begin
      miscompares++;
      $display("FAIL seg_ack_fall got %b want 0", bus.seg_ack);
    end
  endtask

  task automatic load_word(input logic [31:0] w);
    for (int i = 0; i < 8; i++) send_seg(w[i*4 +: 4]);
  endtask

  task automatic read_seg(input logic [3:0] exp);
    bus.rd_req = 1'b1;
    step();
    vectors++;
    if (bus.rd_ack !== 1'b1 || bus.res_seg !== exp) begin
      miscompares++;
      $display("FAIL read_seg got ack=%b seg=%h want ack=1 seg=%h", bus.rd_ack, bus.res_seg, exp);
    end
    bus.rd_req = 1'b0;
    step();
    vectors++;
    if (bus.rd_ack !== 1'b0) begin
      miscompares++;
      $display("FAIL rd_ack_fall got %b want 0", bus.rd_ack);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    vectors++;
    if (bus.busy !== 1'b0 || bus.seg_ack !== 1'b0 || bus.rd_ack !== 1'b0 ||
        bus.pcpi_valid !== 1'b0 || bus.res_avail !== 1'b0 || bus.err !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_flags got busy=%b sack=%b rack=%b valid=%b avail=%b err=%b want all 0",
               bus.busy, bus.seg_ack, bus.rd_ack, bus.pcpi_valid, bus.res_avail, bus.err);
    end
    vectors++;
    if (bus.pcpi_insn !== 32'h0 || bus.res_seg !== 4'h0) begin
      miscompares++;
      $display("FAIL reset_data got insn=%h seg=%h want 0", bus.pcpi_insn, bus.res_seg);
    end
  endtask

  task automatic test_load_exec_drain();
    logic [3:0] segs [8];
    logic [3:0] exp_rd [8];
    segs   = '{4'h8, 4'h7, 4'h6, 4'h5, 4'h4, 4'h3, 4'h2, 4'h1};
    exp_rd = '{4'hF, 4'hE, 4'hE, 4'hB, 4'hD, 4'hA, 4'hE, 4'hD};
    for (int i = 0; i < 7; i++) begin
      send_seg(segs[i]);
      vectors++;
      if (bus.pcpi_valid !== 1'b0 || bus.busy !== 1'b0) begin
        miscompares++;
        $display("FAIL early_valid seg %0d got valid=%b busy=%b want 0", i, bus.pcpi_valid, bus.busy);
      end
    end
    bus.seg_in  = segs[7];
    bus.seg_req = 1'b1;
    step();
    vectors++;
    if (bus.seg_ack !== 1'b1 || bus.pcpi_valid !== 1'b1 || bus.busy !== 1'b1) begin
      miscompares++;
      $display("FAIL last_capture got ack=%b valid=%b busy=%b want 1 1 1", bus.seg_ack, bus.pcpi_valid, bus.busy);
    end
    vectors++;
    if (bus.pcpi_insn !== 32'h12345678) begin
      miscompares++;
      $display("FAIL insn got %h want 12345678", bus.pcpi_insn);
    end
    bus.seg_req = 1'b0;
    step();
    vectors++;
    if (bus.seg_ack !== 1'b0) begin
      miscompares++;
      $display("FAIL exec_ack_release got %b want 0", bus.seg_ack);
    end
    bus.rd_req = 1'b1;
    step();
    step();
    vectors++;
    if (bus.rd_ack !== 1'b0 || bus.pcpi_valid !== 1'b1 || bus.res_avail !== 1'b0) begin
      miscompares++;
      $display("FAIL exec_hold got rack=%b valid=%b avail=%b want 0 1 0", bus.rd_ack, bus.pcpi_valid, bus.res_avail);
    end
    bus.rd_req = 1'b0;
    step();
    bus.pcpi_ready = 1'b1;
    bus.pcpi_wr    = 1'b1;
    bus.pcpi_rd    = 32'hDEADBEEF;
    step();
    bus.pcpi_ready = 1'b0;
    bus.pcpi_wr    = 1'b0;
    bus.pcpi_rd    = 32'h0;
    vectors++;
    if (bus.pcpi_valid !== 1'b0 || bus.res_avail !== 1'b1 || bus.res_seg !== 4'hF) begin
      miscompares++;
      $display("FAIL result_capture got valid=%b avail=%b seg=%h want 0 1 f", bus.pcpi_valid, bus.res_avail, bus.res_seg);
    end
    for (int i = 0; i < 8; i++) read_seg(exp_rd[i]);
    vectors++;
    if (bus.busy !== 1'b0 || bus.res_avail !== 1'b0 || bus.res_seg !== 4'h0) begin
      miscompares++;
      $display("FAIL drain_done got busy=%b avail=%b seg=%h want 0 0 0", bus.busy, bus.res_avail, bus.res_seg);
    end
  endtask

  task automatic test_no_result();
    load_word(32'h000000F0);
    bus.pcpi_ready = 1'b1;
    bus.pcpi_wr    = 1'b0;
    bus.pcpi_rd    = 32'hFFFFFFFF;
    step();
    bus.pcpi_ready = 1'b0;
    bus.pcpi_rd    = 32'h0;
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (bus.busy !== 1'b0 || bus.res_avail !== 1'b0 || bus.pcpi_valid !== 1'b0 || bus.res_seg !== 4'h0) begin
        miscompares++;
        $display("FAIL no_result cyc %0d got busy=%b avail=%b valid=%b seg=%h want 0 0 0 0",
                 i, bus.busy, bus.res_avail, bus.pcpi_valid, bus.res_seg);
      end
      step();
    end
  endtask

  task automatic test_reset_midload();
    send_seg(4'hF);
    send_seg(4'hF);
    send_seg(4'hF);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    vectors++;
    if (bus.pcpi_insn !== 32'h0 || bus.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL midload_reset got insn=%h busy=%b want 0 0", bus.pcpi_insn, bus.busy);
    end
    load_word(32'hA5A5A5A5);
    vectors++;
    if (bus.pcpi_insn !== 32'hA5A5A5A5 || bus.pcpi_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL reload got insn=%h valid=%b want a5a5a5a5 1", bus.pcpi_insn, bus.pcpi_valid);
    end
    for (int i = 0; i < 4; i++) begin
      bus.seg_in  = 4'h3;
      bus.seg_req = ~bus.seg_req;
      step();
      vectors++;
      if (bus.seg_ack !== 1'b0 || bus.pcpi_insn !== 32'hA5A5A5A5) begin
        miscompares++;
        $display("FAIL exec_seg_req cyc %0d got ack=%b insn=%h want 0 a5a5a5a5", i, bus.seg_ack, bus.pcpi_insn);
      end
    end
    bus.seg_req = 1'b0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    vectors++;
    if (bus.pcpi_valid !== 1'b0 || bus.busy !== 1'b0 || bus.pcpi_insn !== 32'h0) begin
      miscompares++;
      $display("FAIL exec_reset got valid=%b busy=%b insn=%h want 0 0 0", bus.pcpi_valid, bus.busy, bus.pcpi_insn);
    end
  endtask

`ifdef PCPI_TIMEOUT_EN
  task automatic test_timeout();
    load_word(32'h00000001);
    for (int i = 0; i < 253; i++) step();
    vectors++;
    if (bus.pcpi_valid !== 1'b1 || bus.err !== 1'b0) begin
      miscompares++;
      $display("FAIL pre_timeout got valid=%b err=%b want 1 0", bus.pcpi_valid, bus.err);
    end
    step();
    vectors++;
    if (bus.pcpi_valid !== 1'b0 || bus.err !== 1'b1 || bus.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL timeout got valid=%b err=%b busy=%b want 0 1 0", bus.pcpi_valid, bus.err, bus.busy);
    end
    bus.pcpi_wait = 1'b1;
    send_seg(4'h2);
    vectors++;
    if (bus.err !== 1'b0) begin
      miscompares++;
      $display("FAIL err_clear got %b want 0", bus.err);
    end
    for (int i = 1; i < 8; i++) send_seg(4'h0);
    for (int i = 0; i < 1000; i++) step();
    vectors++;
    if (bus.pcpi_valid !== 1'b1 || bus.err !== 1'b0 || bus.busy !== 1'b1) begin
      miscompares++;
      $display("FAIL wait_hold got valid=%b err=%b busy=%b want 1 0 1", bus.pcpi_valid, bus.err, bus.busy);
    end
    bus.pcpi_wait  = 1'b0;
    bus.pcpi_ready = 1'b1;
    step();
    bus.pcpi_ready = 1'b0;
    vectors++;
    if (bus.busy !== 1'b0 || bus.err !== 1'b0) begin
      miscompares++;
      $display("FAIL wait_finish got busy=%b err=%b want 0 0", bus.busy, bus.err);
    end
  endtask
`endif

  initial begin
    bus.seg_in     = 4'h0;
    bus.seg_req    = 1'b0;
    bus.rd_req     = 1'b0;
    bus.pcpi_ready = 1'b0;
    bus.pcpi_wr    = 1'b0;
    bus.pcpi_wait  = 1'b0;
    bus.pcpi_rd    = 32'h0;
    test_reset();
    test_load_exec_drain();
    test_no_result();
    test_reset_midload();
`ifdef PCPI_TIMEOUT_EN
    test_timeout();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
